ble_scan_controller: RTL and testbench

Sequences the packet sniffer across the three BLE advertising channels (37, 38, 39) as a periodic scan. It drives the sniffer's enable and channel index, re-arms the dewhitening and CRC state between dwells, and captures each detected packet's length and channel into a valid/ready event interface. It also keeps a saturating packet counter. It sits between the host configuration registers and the sniffer, in the symbol_clk domain.

---
 rtl/ble_pkg.sv | 44 ++++
 rtl/ble_chan_sel.sv | 41 ++++
 rtl/ble_scan_controller.sv | 199 +++++++++++++++++++
 tb/tb_ble_scan_controller.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ble_pkg.sv
// ---------------------------------------------------------------------------
// ble_pkg
// Shared definitions for the BLE advertising-channel scan controller:
//   - advertising channel indices 37/38/39
//   - scan FSM state encoding
//   - advertising access address driven to the sniffer
//   - helpers that map a channel index onto its chan_mask bit
// ---------------------------------------------------------------------------
package ble_pkg;

   localparam logic [5:0]  CH_ADV37        = 6'd37;
   localparam logic [5:0]  CH_ADV38        = 6'd38;
   localparam logic [5:0]  CH_ADV39        = 6'd39;
   localparam logic [31:0] ADV_ACCESS_ADDR = 32'h8E89BED6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_LISTEN = 2'd2,
      ST_REPORT = 2'd3
   } scan_state_t;

   // Lowest-numbered enabled advertising channel (39 when mask is empty).
   function automatic logic [5:0] lowest_chan(input logic [2:0] mask);
      logic [5:0] result;
      if (mask[0])      result = CH_ADV37;
      else if (mask[1]) result = CH_ADV38;
      else              result = CH_ADV39;
      return result;
   endfunction

   // True when the given channel is enabled in the mask.
   function automatic logic chan_enabled(input logic [5:0] ch, input logic [2:0] mask);
      logic result;
      case (ch)
         CH_ADV37: result = mask[0];
         CH_ADV38: result = mask[1];
         CH_ADV39: result = mask[2];
         default:  result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/ble_chan_sel.sv
// ---------------------------------------------------------------------------
// ble_chan_sel
// Combinational next-enabled-channel picker. Walks 37 -> 38 -> 39 -> 37
// starting after the current channel and returns the first enabled one.
// With a single channel enabled this returns that channel; with an empty
// mask the current channel is returned unchanged.
// Ports:
//   i_channel       current advertising channel (37..39)
//   i_chan_mask     bit0 = 37, bit1 = 38, bit2 = 39
//   o_next_channel  next enabled channel in hop order
// ---------------------------------------------------------------------------
module ble_chan_sel
   import ble_pkg::*;
(
   input  logic [5:0] i_channel,
   input  logic [2:0] i_chan_mask,
   output logic [5:0] o_next_channel
);

   always_comb begin
      o_next_channel = i_channel;
      case (i_channel)
         CH_ADV37: begin
            if (i_chan_mask[1])      o_next_channel = CH_ADV38;
            else if (i_chan_mask[2]) o_next_channel = CH_ADV39;
            else if (i_chan_mask[0]) o_next_channel = CH_ADV37;
         end
         CH_ADV38: begin
            if (i_chan_mask[2])      o_next_channel = CH_ADV39;
            else if (i_chan_mask[0]) o_next_channel = CH_ADV37;
            else if (i_chan_mask[1]) o_next_channel = CH_ADV38;
         end
         default: begin
            if (i_chan_mask[0])      o_next_channel = CH_ADV37;
            else if (i_chan_mask[1]) o_next_channel = CH_ADV38;
            else if (i_chan_mask[2]) o_next_channel = CH_ADV39;
         end
      endcase
   end

endmodule

// File: rtl/ble_scan_controller.sv
// ---------------------------------------------------------------------------
// ble_scan_controller
// Periodic scan across BLE advertising channels 37/38/39. Each dwell is a
// SETTLE phase (sniffer disabled, re-arming dewhitening/CRC) followed by a
// LISTEN phase; both phases consume the dwell budget. A rising edge of
// i_packet_detected while listening captures length/channel into a
// valid/ready event and pauses the dwell until the event is accepted.
// Ports:
//   symbol_clk, rst      clock (posedge) / async active-low reset
//   i_scan_en            scanning requested
//   i_chan_mask          channel enables (bit0=37, bit1=38, bit2=39)
//   i_dwell_cycles       dwell length per channel (0 treated as 1)
//   i_packet_detected    sniffer packet flag (edge detected)
//   i_packet_len         sniffer packet length
//   o_sniffer_en         sniffer enable
//   o_channel            channel index to the sniffer
//   o_evt_valid/i_evt_ready, o_evt_channel, o_evt_len   event interface
//   o_pkt_count          saturating packet counter
//   o_scan_busy          high whenever not IDLE
//   o_acc_addr           advertising access address for the sniffer
// ---------------------------------------------------------------------------
module ble_scan_controller
   import ble_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int DWELL_W       = 16,
   parameter int CNT_W         = 16
) (
   input  logic               symbol_clk,
   input  logic               rst,
   input  logic               i_scan_en,
   input  logic [2:0]         i_chan_mask,
   input  logic [DWELL_W-1:0] i_dwell_cycles,
   input  logic               i_packet_detected,
   input  logic [8:0]         i_packet_len,
   output logic               o_sniffer_en,
   output logic [5:0]         o_channel,
   output logic               o_evt_valid,
   input  logic               i_evt_ready,
   output logic [5:0]         o_evt_channel,
   output logic [8:0]         o_evt_len,
   output logic [CNT_W-1:0]   o_pkt_count,
   output logic               o_scan_busy,
   output logic [31:0]        o_acc_addr
);

   localparam int               SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

   scan_state_t        r_state;
   logic [SET_W-1:0]   r_settle_cnt;
   logic [DWELL_W-1:0] r_dwell_cnt;
   logic               r_pd_q;
   logic               r_sniffer_en;
   logic [5:0]         r_channel;
   logic               r_evt_valid;
   logic [5:0]         r_evt_channel;
   logic [8:0]         r_evt_len;
   logic [CNT_W-1:0]   r_pkt_count;
   logic               r_scan_busy;

   logic [5:0]         w_next_chan;
   logic [DWELL_W-1:0] w_dwell_last;
   logic [DWELL_W-1:0] w_dwell_inc;
   logic               w_dwell_expired;
   logic               w_stop;
   logic               w_pkt_edge;
   logic               w_handshake;

   ble_chan_sel u_chan_sel (
      .i_channel      (r_channel),
      .i_chan_mask    (i_chan_mask),
      .o_next_channel (w_next_chan)
   );

   assign w_dwell_last    = (i_dwell_cycles == '0) ? '0 : i_dwell_cycles - DWELL_W'(1);
   // Saturating increment keeps the counter from wrapping past a huge dwell
   // while SETTLE keeps counting after a resumed REPORT.
   assign w_dwell_inc     = (r_dwell_cnt == '1) ? r_dwell_cnt : r_dwell_cnt + DWELL_W'(1);
   // >= rather than == so a dwell shorter than the settle phase still ends.
   assign w_dwell_expired = (r_dwell_cnt >= w_dwell_last);
   assign w_stop          = !i_scan_en || (i_chan_mask == 3'b000);
   assign w_pkt_edge      = i_packet_detected && !r_pd_q;
   assign w_handshake     = r_evt_valid && i_evt_ready;

   always_ff @(posedge symbol_clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_settle_cnt  <= '0;
         r_dwell_cnt   <= '0;
         r_pd_q        <= 1'b0;
         r_sniffer_en  <= 1'b0;
         r_channel     <= CH_ADV37;
         r_evt_valid   <= 1'b0;
         r_evt_channel <= '0;
         r_evt_len     <= '0;
         r_pkt_count   <= '0;
         r_scan_busy   <= 1'b0;
      end else begin
         r_pd_q <= i_packet_detected;
         case (r_state)
            ST_IDLE: begin
               if (!w_stop) begin
                  r_state      <= ST_SETTLE;
                  r_scan_busy  <= 1'b1;
                  r_channel    <= lowest_chan(i_chan_mask);
                  r_settle_cnt <= '0;
                  r_dwell_cnt  <= '0;
               end
            end
            ST_SETTLE: begin
               if (w_stop) begin
                  r_state      <= ST_IDLE;
                  r_scan_busy  <= 1'b0;
                  r_sniffer_en <= 1'b0;
                  r_settle_cnt <= '0;
                  r_dwell_cnt  <= '0;
               end else begin
                  r_dwell_cnt <= w_dwell_inc;
                  if (r_settle_cnt == SETTLE_LAST) begin
                     r_settle_cnt <= '0;
                     if (w_dwell_expired) begin
                        // Budget used up by settling alone: hop without listening.
                        r_channel   <= w_next_chan;
                        r_dwell_cnt <= '0;
                     end else begin
                        r_state      <= ST_LISTEN;
                        r_sniffer_en <= 1'b1;
                     end
                  end else begin
                     r_settle_cnt <= r_settle_cnt + SET_W'(1);
                  end
               end
            end
            ST_LISTEN: begin
               if (w_stop) begin
                  r_state      <= ST_IDLE;
                  r_scan_busy  <= 1'b0;
                  r_sniffer_en <= 1'b0;
                  r_settle_cnt <= '0;
                  r_dwell_cnt  <= '0;
               end else if (w_pkt_edge) begin
                  // Packet wins over a coincident expiry; the counter stays put
                  // so the hop decision is taken again after REPORT.
                  r_state       <= ST_REPORT;
                  r_sniffer_en  <= 1'b0;
                  r_evt_valid   <= 1'b1;
                  r_evt_len     <= i_packet_len;
                  r_evt_channel <= r_channel;
                  if (r_pkt_count != '1) r_pkt_count <= r_pkt_count + CNT_W'(1);
               end else if (w_dwell_expired) begin
                  r_state      <= ST_SETTLE;
                  r_sniffer_en <= 1'b0;
                  r_channel    <= w_next_chan;
                  r_dwell_cnt  <= '0;
                  r_settle_cnt <= '0;
               end else begin
                  r_dwell_cnt <= w_dwell_inc;
               end
            end
            ST_REPORT: begin
               if (w_handshake) begin
                  r_evt_valid <= 1'b0;
                  if (w_stop) begin
                     r_state      <= ST_IDLE;
                     r_scan_busy  <= 1'b0;
                     r_settle_cnt <= '0;
                     r_dwell_cnt  <= '0;
                  end else begin
                     r_state      <= ST_SETTLE;
                     r_settle_cnt <= '0;
                     // Hop if the dwell ran out, or the mask dropped this channel.
                     if (w_dwell_expired || !chan_enabled(r_channel, i_chan_mask)) begin
                        r_channel   <= w_next_chan;
                        r_dwell_cnt <= '0;
                     end
                  end
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_scan_busy  <= 1'b0;
               r_sniffer_en <= 1'b0;
               r_evt_valid  <= 1'b0;
            end
         endcase
      end
   end

   assign o_sniffer_en  = r_sniffer_en;
   assign o_channel     = r_channel;
   assign o_evt_valid   = r_evt_valid;
   assign o_evt_channel = r_evt_channel;
   assign o_evt_len     = r_evt_len;
   assign o_pkt_count   = r_pkt_count;
   assign o_scan_busy   = r_scan_busy;
   assign o_acc_addr    = ADV_ACCESS_ADDR;

endmodule

// File: tb/tb_ble_scan_controller.sv
`timescale 1ns/1ps
module tb_ble_scan_controller;

   logic        symbol_clk = 1'b0;
   logic        rst = 1'b0;
   logic        scan_en = 1'b0;
   logic [2:0]  chan_mask = 3'b000;
   logic [15:0] dwell = 16'd10;
   logic        pd = 1'b0;
   logic [8:0]  plen = 9'd0;
   logic        evt_ready = 1'b0;

   logic        sniffer_en, evt_valid, scan_busy;
   logic [5:0]  channel, evt_channel;
   logic [8:0]  evt_len;
   logic [15:0] pkt_count;
   logic [31:0] acc_addr;

   logic        s4_sniffer_en, s4_evt_valid, s4_scan_busy;
   logic [5:0]  s4_channel, s4_evt_channel;
   logic [8:0]  s4_evt_len;
   logic [3:0]  s4_pkt_count;
   logic [31:0] s4_acc_addr;

   ble_scan_controller #(.SETTLE_CYCLES(4), .DWELL_W(16), .CNT_W(16)) dut (
      .symbol_clk(symbol_clk), .rst(rst), .i_scan_en(scan_en), .i_chan_mask(chan_mask),
      .i_dwell_cycles(dwell), .i_packet_detected(pd), .i_packet_len(plen),
      .o_sniffer_en(sniffer_en), .o_channel(channel), .o_evt_valid(evt_valid),
      .i_evt_ready(evt_ready), .o_evt_channel(evt_channel), .o_evt_len(evt_len),
      .o_pkt_count(pkt_count), .o_scan_busy(scan_busy), .o_acc_addr(acc_addr)
   );

   ble_scan_controller #(.SETTLE_CYCLES(4), .DWELL_W(16), .CNT_W(4)) dut4 (
      .symbol_clk(symbol_clk), .rst(rst), .i_scan_en(scan_en), .i_chan_mask(chan_mask),
      .i_dwell_cycles(dwell), .i_packet_detected(pd), .i_packet_len(plen),
      .o_sniffer_en(s4_sniffer_en), .o_channel(s4_channel), .o_evt_valid(s4_evt_valid),
      .i_evt_ready(evt_ready), .o_evt_channel(s4_evt_channel), .o_evt_len(s4_evt_len),
      .o_pkt_count(s4_pkt_count), .o_scan_busy(s4_scan_busy), .o_acc_addr(s4_acc_addr)
   );

   always #5 symbol_clk = ~symbol_clk;

   typedef struct packed {
      logic [8:0] len;
      logic [5:0] ch;
   } evt_t;

   evt_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   n_pkts = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic push_exp(input logic [8:0] l, input logic [5:0] c);
      evt_t e;
      e.len = l;
      e.ch  = c;
      exp_q.push_back(e);
      n_pkts++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge symbol_clk);
   endtask

   // Negedges until sniffer_en is seen high (bounded).
   task automatic count_until_en(output int k);
      k = 0;
      while (sniffer_en !== 1'b1 && k < 100) begin
         @(negedge symbol_clk);
         k++;
      end
      if (sniffer_en !== 1'b1) check("wait_sniffer_en", {31'd0, sniffer_en}, 32'd1);
   endtask

   // Length in cycles of the current listen window and the channel during it.
   task automatic measure_window(output int len, output logic [5:0] ch);
      len = 0;
      ch  = channel;
      while (sniffer_en === 1'b1 && len < 100) begin
         ch = channel;
         @(negedge symbol_clk);
         len++;
      end
   endtask

   // Scoreboard monitor: samples mid-cycle, after the bench has driven the
   // inputs for the coming edge, so valid&&ready here is a handshake.
   initial begin
      evt_t e;
      forever begin
         @(negedge symbol_clk);
         #2;
         if (rst && evt_valid && evt_ready) begin
            check("pending_events", {31'd0, (exp_q.size() != 0)}, 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("evt_len", {23'd0, evt_len}, {23'd0, e.len});
               check("evt_channel", {26'd0, evt_channel}, {26'd0, e.ch});
               $display("event handshake: len=%0d channel=%0d", evt_len, evt_channel);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, len, bad;
      logic [5:0] ch;
      logic [5:0] exp_hop [4];
      exp_hop[0] = 6'd37; exp_hop[1] = 6'd38; exp_hop[2] = 6'd39; exp_hop[3] = 6'd37;

      // ---------------- reset state
      tick(2);
      check("rst_sniffer_en", {31'd0, sniffer_en}, 32'd0);
      check("rst_channel", {26'd0, channel}, 32'd37);
      check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
      check("rst_evt_channel", {26'd0, evt_channel}, 32'd0);
      check("rst_evt_len", {23'd0, evt_len}, 32'd0);
      check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
      check("rst_scan_busy", {31'd0, scan_busy}, 32'd0);
      check("acc_addr", acc_addr, 32'h8E89BED6);
      rst = 1'b1;
      chan_mask = 3'b111;
      dwell = 16'd10;
      tick(2);
      check("idle_no_scan_busy", {31'd0, scan_busy}, 32'd0);

      // ---------------- basic hop
      scan_en = 1'b1;
      tick(1);
      check("hop_busy", {31'd0, scan_busy}, 32'd1);
      check("hop_first_channel", {26'd0, channel}, 32'd37);
      count_until_en(k);
      check("hop_settle_len", k, 32'd4);
      for (int w = 0; w < 4; w++) begin
         measure_window(len, ch);
         $display("window %0d: channel=%0d len=%0d", w, ch, len);
         check("hop_window_len", len, 32'd6);
         check("hop_window_channel", {26'd0, ch}, {26'd0, exp_hop[w]});
         if (w < 3) begin
            count_until_en(k);
            check("hop_gap", k, 32'd4);
         end
      end

      // ---------------- stop in LISTEN
      count_until_en(k);
      tick(2);
      scan_en = 1'b0;
      tick(1);
      check("stop_listen_busy", {31'd0, scan_busy}, 32'd0);
      check("stop_listen_en", {31'd0, sniffer_en}, 32'd0);

      // ---------------- packet capture on 38
      evt_ready = 1'b1;
      scan_en = 1'b1;
      tick(1);
      count_until_en(k);
      measure_window(len, ch);
      count_until_en(k);
      pd = 1'b1; plen = 9'd80;
      push_exp(9'd80, 6'd38);
      tick(1);
      pd = 1'b0;
      check("cap_evt_valid", {31'd0, evt_valid}, 32'd1);
      check("cap_evt_len", {23'd0, evt_len}, 32'd80);
      check("cap_evt_channel", {26'd0, evt_channel}, 32'd38);
      check("cap_sniffer_off", {31'd0, sniffer_en}, 32'd0);
      check("cap_pkt_count", {16'd0, pkt_count}, n_pkts);
      tick(1);
      check("cap_valid_drop", {31'd0, evt_valid}, 32'd0);
      count_until_en(k);
      check("cap_resettle", k, 32'd4);
      measure_window(len, ch);
      check("cap_remain_len", len, 32'd2);
      check("cap_remain_channel", {26'd0, ch}, 32'd38);

      // ---------------- backpressure on 39
      count_until_en(k);
      evt_ready = 1'b0;
      pd = 1'b1; plen = 9'd123;
      push_exp(9'd123, 6'd39);
      tick(1);
      pd = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (!(evt_valid === 1'b1 && evt_len === 9'd123 && evt_channel === 6'd39 &&
               sniffer_en === 1'b0 && scan_busy === 1'b1)) bad++;
         tick(1);
      end
      check("bp_hold_bad_cycles", bad, 32'd0);
      evt_ready = 1'b1;
      tick(1);
      check("bp_release_valid", {31'd0, evt_valid}, 32'd0);
      count_until_en(k);
      check("bp_resettle", k, 32'd4);
      measure_window(len, ch);
      check("bp_frozen_remain_len", len, 32'd2);
      check("bp_frozen_remain_channel", {26'd0, ch}, 32'd39);

      // ---------------- collision: packet edge on the expiry cycle of 37
      count_until_en(k);
      tick(5);
      check("coll_still_listening", {31'd0, sniffer_en}, 32'd1);
      pd = 1'b1; plen = 9'd200;
      push_exp(9'd200, 6'd37);
      tick(1);
      pd = 1'b0;
      check("coll_evt_valid", {31'd0, evt_valid}, 32'd1);
      tick(1);
      check("coll_hop_channel", {26'd0, channel}, 32'd38);
      check("coll_valid_drop", {31'd0, evt_valid}, 32'd0);
      count_until_en(k);
      check("coll_settle", k, 32'd4);
      measure_window(len, ch);
      check("coll_full_window_len", len, 32'd6);
      check("coll_full_window_channel", {26'd0, ch}, 32'd38);

      // ---------------- packet_detected held high counts once
      count_until_en(k);
      pd = 1'b1; plen = 9'd55;
      push_exp(9'd55, 6'd39);
      tick(12);
      pd = 1'b0;
      tick(2);
      check("held_pkt_count", {16'd0, pkt_count}, n_pkts);
      scan_en = 1'b0;
      tick(2);

      // ---------------- mask 3'b100: stays on 39
      chan_mask = 3'b100;
      scan_en = 1'b1;
      tick(1);
      check("m100_channel", {26'd0, channel}, 32'd39);
      count_until_en(k);
      check("m100_settle", k, 32'd4);
      measure_window(len, ch);
      check("m100_len", len, 32'd6);
      check("m100_channel_win", {26'd0, ch}, 32'd39);
      count_until_en(k);
      check("m100_resettle", k, 32'd4);
      measure_window(len, ch);
      check("m100_channel_win2", {26'd0, ch}, 32'd39);
      scan_en = 1'b0;
      tick(2);

      // ---------------- mask 0: no scan
      chan_mask = 3'b000;
      scan_en = 1'b1;
      tick(5);
      check("m0_scan_busy", {31'd0, scan_busy}, 32'd0);
      check("m0_sniffer_en", {31'd0, sniffer_en}, 32'd0);
      scan_en = 1'b0;
      tick(1);

      // ---------------- dwell 0 and 1: settle-only hops every 4 cycles
      chan_mask = 3'b111;
      for (int d = 0; d < 2; d++) begin
         dwell = 16'(d);
         scan_en = 1'b1;
         tick(1);
         bad = 0;
         for (int i = 0; i < 12; i++) begin
            if (sniffer_en !== 1'b0) bad++;
            if (channel !== 6'(37 + (i / 4) % 3)) bad++;
            tick(1);
         end
         check(d == 0 ? "dwell0_seq_bad" : "dwell1_seq_bad", bad, 32'd0);
         scan_en = 1'b0;
         tick(2);
      end

      // ---------------- saturation: 20 packets on channel 38
      dwell = 16'd10;
      chan_mask = 3'b010;
      evt_ready = 1'b1;
      scan_en = 1'b1;
      tick(1);
      for (int i = 0; i < 20; i++) begin
         count_until_en(k);
         pd = 1'b1; plen = 9'(i + 1);
         push_exp(9'(i + 1), 6'd38);
         tick(1);
         pd = 1'b0;
         tick(1);
      end
      check("sat_cnt4_pkt_count", {28'd0, s4_pkt_count}, 32'd15);
      check("sat_main_pkt_count", {16'd0, pkt_count}, n_pkts);

      // ---------------- stop during REPORT
      count_until_en(k);
      evt_ready = 1'b0;
      pd = 1'b1; plen = 9'd77;
      push_exp(9'd77, 6'd38);
      tick(1);
      pd = 1'b0;
      scan_en = 1'b0;
      tick(3);
      check("stop_rep_valid_held", {31'd0, evt_valid}, 32'd1);
      check("stop_rep_busy_held", {31'd0, scan_busy}, 32'd1);
      evt_ready = 1'b1;
      tick(1);
      check("stop_rep_valid", {31'd0, evt_valid}, 32'd0);
      check("stop_rep_idle", {31'd0, scan_busy}, 32'd0);
      check("stop_rep_en", {31'd0, sniffer_en}, 32'd0);

      // ---------------- async reset during REPORT
      evt_ready = 1'b0;
      scan_en = 1'b1;
      tick(1);
      count_until_en(k);
      pd = 1'b1; plen = 9'd99;
      tick(1);
      pd = 1'b0;
      check("rr_in_report", {31'd0, evt_valid}, 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("rr_evt_valid", {31'd0, evt_valid}, 32'd0);
      check("rr_sniffer_en", {31'd0, sniffer_en}, 32'd0);
      check("rr_channel", {26'd0, channel}, 32'd37);
      check("rr_evt_channel", {26'd0, evt_channel}, 32'd0);
      check("rr_evt_len", {23'd0, evt_len}, 32'd0);
      check("rr_pkt_count", {16'd0, pkt_count}, 32'd0);
      check("rr_scan_busy", {31'd0, scan_busy}, 32'd0);
      tick(2);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
